// File: rtl/flow_ctrl_pkg.sv
// Shared types and helpers for the pipeline flow controller: cache FSM states,
// stage indices and extraction of 4-bit stage fields from packed parameters.
package flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MISS  = 2'd1,
    ST_DRAIN = 2'd2
  } cache_st_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int MAX_FIELDS = 16;

  function automatic int stg_field(input logic [4*MAX_FIELDS-1:0] vec, input int idx);
    logic [3:0] f;
    f = vec[idx*4 +: 4];
    return int'(f);
  endfunction

  // Originating stage of redirect source idx.
  function automatic int redir_stg(input logic [4*MAX_FIELDS-1:0] vec, input int idx);
    return stg_field(vec, idx);
  endfunction

  function automatic int cache_stg(input logic [4*MAX_FIELDS-1:0] vec, input int idx);
    return stg_field(vec, idx);
  endfunction

endpackage

// File: rtl/cache_stall_fsm.sv
// Per-cache miss FSM (IDLE/MISS/DRAIN) with same-cycle stall generation and a
// saturating stall-cycle counter.
module cache_stall_fsm
  import flow_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic             i_ready,
  input  logic             i_hit,
  input  logic             i_cancel,
  output logic             o_stall,
  output logic             o_data_valid,
  output logic             o_in_miss,
  output logic [CNT_W-1:0] o_stall_cnt
);

  cache_st_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;
  logic             w_dv;

  // Stall and data-valid are decoded from state and live inputs so the stall
  // takes effect in the very cycle the miss is seen.
  always_comb begin
    w_stall = 1'b0;
    w_dv    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          w_stall = i_req & ~i_ready;
          w_dv    = i_ready;
        end
        ST_MISS: begin
          w_stall = ~i_ready;
          w_dv    = i_ready;
        end
        ST_DRAIN: begin
          w_stall = ~(i_ready | i_hit);
          w_dv    = 1'b0;
        end
        default: begin
          w_stall = 1'b0;
          w_dv    = 1'b0;
        end
      endcase
    end else begin
      w_stall = 1'b0;
      w_dv    = 1'b0;
    end
  end

  // State transitions and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= (i_req && !i_ready) ? ST_MISS : ST_IDLE;
        // A refill that completes in the same cycle as a cancel simply retires.
        ST_MISS:  r_state <= i_ready ? ST_IDLE : (i_cancel ? ST_DRAIN : ST_MISS);
        ST_DRAIN: r_state <= (i_ready || i_hit) ? ST_IDLE : ST_DRAIN;
        default:  r_state <= ST_IDLE;
      endcase
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_stall      = w_stall;
  assign o_data_valid = w_dv;
  assign o_in_miss    = (r_state == ST_MISS);
  assign o_stall_cnt  = r_cnt;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: combines per-cache stalls into stage stall/flush
// vectors, arbitrates redirects and buffers a redirect that arrives while IF is frozen.
module pipe_flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int                     XLEN      = 32,
  parameter int                     N_STAGE   = 5,
  parameter int                     N_REDIR   = 2,
  parameter logic [N_REDIR*4-1:0]   REDIR_STG = {4'd1, 4'd2},
  parameter int                     N_CACHE   = 2,
  parameter logic [N_CACHE*4-1:0]   CACHE_STG = {4'd3, 4'd0},
  parameter int                     CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REDIR-1:0]        redir_valid_i,
  input  logic [N_REDIR*XLEN-1:0]   redir_pc_i,
  input  logic [N_CACHE-1:0]        cache_req_i,
  input  logic [N_CACHE-1:0]        cache_ready_i,
  input  logic [N_CACHE-1:0]        cache_hit_i,
  output logic [N_CACHE-1:0]        cache_cancel_o,
  output logic [N_CACHE-1:0]        cache_data_valid_o,
  output logic [N_STAGE-1:0]        stall_o,
  output logic [N_STAGE-1:0]        flush_o,
  output logic                      fc_jump_flag_o,
  output logic [XLEN-1:0]           fc_jump_pc_o,
  output logic [N_CACHE*CNT_W-1:0]  perf_stall_cnt_o,
  output logic [CNT_W-1:0]          perf_redir_cnt_o
);

  logic [N_CACHE-1:0] w_stall_k;
  logic [N_CACHE-1:0] w_in_miss;
  logic [N_CACHE-1:0] w_cancel;
  logic [N_STAGE-1:0] w_stall_vec;
  logic [N_STAGE-1:0] w_flush;
  logic               w_win_found;
  logic [XLEN-1:0]    w_win_pc;
  int                 w_win_stg;
  logic               w_win_stalled;
  logic               w_accept;
  logic               w_jump_flag;
  logic [XLEN-1:0]    w_jump_pc;

  logic               r_pend_valid;
  logic [XLEN-1:0]    r_pend_pc;
  logic [CNT_W-1:0]   r_redir_cnt;

  for (genvar k = 0; k < N_CACHE; k++) begin : g_cache
    cache_stall_fsm #(.CNT_W(CNT_W)) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req        (cache_req_i[k]),
      .i_ready      (cache_ready_i[k]),
      .i_hit        (cache_hit_i[k]),
      .i_cancel     (w_cancel[k]),
      .o_stall      (w_stall_k[k]),
      .o_data_valid (cache_data_valid_o[k]),
      .o_in_miss    (w_in_miss[k]),
      .o_stall_cnt  (perf_stall_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  // A stalled cache freezes its own stage and everything upstream of it.
  always_comb begin
    w_stall_vec = '0;
    for (int s = 0; s < N_STAGE; s++) begin
      for (int k = 0; k < N_CACHE; k++) begin
        w_stall_vec[s] = w_stall_vec[s] | (w_stall_k[k] & (s <= cache_stg(64'(CACHE_STG), k)));
      end
    end
  end

  // Fixed-priority pick: scanning downwards leaves the lowest valid index.
  always_comb begin
    w_win_found = 1'b0;
    w_win_pc    = '0;
    w_win_stg   = 0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      w_win_pc    = redir_valid_i[i] ? redir_pc_i[i*XLEN +: XLEN] : w_win_pc;
      w_win_stg   = redir_valid_i[i] ? redir_stg(64'(REDIR_STG), i) : w_win_stg;
      w_win_found = w_win_found | redir_valid_i[i];
    end
    w_win_stalled = 1'b0;
    for (int s = 0; s < N_STAGE; s++) begin
      w_win_stalled = w_win_stalled | ((s == w_win_stg) & w_stall_vec[s]);
    end
    w_accept = rst_n & w_win_found & ~w_win_stalled;
  end

  // Flush everything younger than the redirecting stage; abort in-flight I-side refills.
  always_comb begin
    w_flush  = '0;
    w_cancel = '0;
    for (int s = 0; s < N_STAGE; s++) begin
      w_flush[s] = w_accept & (s < w_win_stg);
    end
    for (int k = 0; k < N_CACHE; k++) begin
      w_cancel[k] = w_accept & w_in_miss[k] & (cache_stg(64'(CACHE_STG), k) == STG_IF);
    end
  end

  // A fresh accepted redirect beats the buffered one; both need IF unfrozen.
  always_comb begin
    w_jump_flag = 1'b0;
    w_jump_pc   = '0;
    if (rst_n && !w_stall_vec[0] && w_accept) begin
      w_jump_flag = 1'b1;
      w_jump_pc   = w_win_pc;
    end else if (rst_n && !w_stall_vec[0] && r_pend_valid) begin
      w_jump_flag = 1'b1;
      w_jump_pc   = r_pend_pc;
    end else begin
      w_jump_flag = 1'b0;
      w_jump_pc   = '0;
    end
  end

  // Pending redirect register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else if (w_accept && w_stall_vec[0]) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= w_win_pc;
    end else if (!w_stall_vec[0]) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      r_pend_valid <= r_pend_valid;
      r_pend_pc    <= r_pend_pc;
    end
  end

  // Saturating accepted-redirect counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_redir_cnt <= {CNT_W{1'b0}};
    end else if (w_accept && (r_redir_cnt != {CNT_W{1'b1}})) begin
      r_redir_cnt <= r_redir_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_redir_cnt <= r_redir_cnt;
    end
  end

  assign cache_cancel_o   = w_cancel;
  assign stall_o          = w_stall_vec;
  assign flush_o          = w_flush;
  assign fc_jump_flag_o   = w_jump_flag;
  assign fc_jump_pc_o     = w_jump_pc;
  assign perf_redir_cnt_o = r_redir_cnt;

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Parametrised pipeline flow controller, the successor to the core's single-purpose stall/flush unit. It serves N_STAGE pipeline stages, N_REDIR prioritised redirect sources (branch/jump) and N_CACHE cache ports, each with its own miss FSM. It produces per-stage stall and flush vectors, a single PC redirect, and per-cache refill-cancel pulses. It buffers a redirect that arrives while IF is frozen, and keeps saturating performance counters.

Parameters:
XLEN, 32, PC width
N_STAGE, 5, pipeline stages; stage 0 = IF, stage N_STAGE-1 = WB
N_REDIR, 2, redirect sources; index 0 has highest priority
REDIR_STG, {4'd1,4'd2}, packed 4-bit originating stage per source; source 0 = EX(2), source 1 = ID(1)
N_CACHE, 2, cache ports
CACHE_STG, {4'd3,4'd0}, packed 4-bit stage served per cache; cache 0 = IF(0), cache 1 = MEM(3)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
redir_valid_i  in  N_REDIR  redirect request per source
redir_pc_i  in  N_REDIR*XLEN  redirect target per source
cache_req_i  in  N_CACHE  valid access request from the served stage
cache_ready_i  in  N_CACHE  cache data ready
cache_hit_i  in  N_CACHE  cache hit
cache_cancel_o  out  N_CACHE  one-cycle pulse that aborts an outstanding refill
cache_data_valid_o  out  N_CACHE  returned data usable by the pipeline
stall_o  out  N_STAGE  per-stage freeze
flush_o  out  N_STAGE  per-stage bubble insert
fc_jump_flag_o  out  1  load PC with fc_jump_pc_o
fc_jump_pc_o  out  XLEN  redirect target; 0 when fc_jump_flag_o=0
perf_stall_cnt_o  out  N_CACHE*CNT_W  stall cycles per cache
perf_redir_cnt_o  out  CNT_W  accepted redirects

Behaviour:
- Reset (rst_n=0 at a clk edge): all FSMs go to IDLE, the pending redirect is cleared, counters clear, and every output is 0. Reset asserted mid-miss or mid-pending discards that state.
- Per-cache FSM k, states IDLE/MISS/DRAIN:
  - IDLE: cache_req_i&~cache_ready_i asserts stall_k combinationally in the same cycle and moves to MISS. req&ready means no stall.
  - MISS: stall_k=1. When ready=1: stall_k=0 and data_valid=1 in that cycle, then go to IDLE. A cancel in MISS moves to DRAIN.
  - DRAIN: stall_k=1 and data_valid forced 0. The FSM waits for ready|hit, then stall_k=0 that cycle and it returns to IDLE.
- cache_data_valid_o[k] = cache_ready_i[k] except in DRAIN.
- stall_o[s] = OR of stall_k over all k with s <= CACHE_STG_k.
- Redirect arbitration:
  - Winner w is the lowest valid index.
  - w is accepted only if stall_o[REDIR_STG_w]=0; otherwise the source holds its request.
  - On accept: flush_o[s]=1 for all s < REDIR_STG_w, for one cycle. perf_redir_cnt increments.
  - For every cache in MISS with CACHE_STG=0, cache_cancel_o pulses and that FSM goes to DRAIN.
- Jump output:
  - If accepted and stall_o[0]=0, fc_jump_flag_o=1 with pc_w in the same cycle (zero latency).
  - If accepted and stall_o[0]=1, the redirect is latched in the pending register.
  - While pending, fc_jump_flag_o=1 for exactly one cycle, with the pending pc, in the first cycle stall_o[0]=0. The pending register clears at that edge.
  - A new accepted redirect overwrites the pending one. Any redirect still surviving after a flush is older in program order.
  - Pending and a same-cycle accept with stall_o[0]=0: the new pc wins and pending clears.
- Counters saturate at all-ones and never wrap.
  - perf_stall_cnt[k] increments each cycle stall_k=1.

Decomposition:
- Package flow_ctrl_pkg holds:
  - FSM state encoding (IDLE=2'd0, MISS=2'd1, DRAIN=2'd2)
  - stage index constants STG_IF/ID/EX/MEM/WB
  - helper functions for the packed-field extraction of REDIR_STG and CACHE_STG
- One sub-module, cache_stall_fsm: FSM plus stall counter, instantiated N_CACHE times via generate.
- Top level holds arbitration, pending register, vector build and redirect counter.

Test Plan:
1. I-miss: req[0]=1, ready[0]=0 for 4 cycles, then ready=1 -> stall_o=5'b00001 for 4 cycles, 0 on the ready cycle; data_valid[0]=1 that cycle; perf_stall_cnt[0]=4.
2. D-miss: req[1]=1, ready=0 for 3 cycles -> stall_o=5'b01111 for 3 cycles; ready cycle stall_o=0; perf_stall_cnt[1]=3.
3. EX redirect pc=0x100 during I-miss -> flush_o=5'b00011 and cancel_o[0]=1 for one cycle; fc_jump_flag_o=0; FSM enters DRAIN. On hit[0]=1 -> fc_jump_flag_o=1 with pc 0x100 for one cycle; data_valid[0]=0 throughout DRAIN.
4. Simultaneous ID 0x200 and EX 0x300, no stall -> same cycle fc_jump_pc_o=0x300, flush_o=5'b00011; perf_redir_cnt +1 only.
5. ID redirect 0x200 held during D-miss -> no flush/jump while stalled. The cycle stall drops -> jump 0x200, flush_o=5'b00001.
6. rst_n=0 while in MISS with a pending redirect -> after one edge: all outputs 0, counters 0, no jump after release.
